systolic_feeder: RTL and testbench

- Synthesizable driver for the `systolic` array's load/weights/activations interface; does in hardware what the array bench does by hand.
- Buffers one full weight tile from an upstream valid/ready stream, then replays it into the array as a contiguous load burst.
- Then accepts activation vectors and skews them into a diagonal wavefront, drains with zeros, and signals completion.
- Sits between the on-chip buffer/DMA layer and `systolic`.

---
 rtl/systolic_feeder.sv | 169 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Weight-tile buffer and activation skewer that feeds a systolic array:
// fill a tile, replay it as a load burst, stream a diagonal wavefront, drain.
module systolic_feeder #(
  parameter int ARRAY_SIZE   = 8,
  parameter int DATA_WIDTH   = 4,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_data,
  input  logic                             a_valid,
  output logic                             a_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_data,
  input  logic                             a_last,
  output logic                             load,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] weights,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] activations,
  output logic                             busy,
  output logic                             done
);

  localparam int VW = ARRAY_SIZE * DATA_WIDTH;
  localparam int IW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(ARRAY_SIZE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [IW-1:0] row_cnt_r, row_cnt_s;
  logic [IW-1:0] load_idx_r, load_idx_s;
  logic [CW-1:0] drain_cnt_r, drain_cnt_s;
  logic          w_acc_s, a_acc_s, done_s;
  logic [VW-1:0] skew_in_s;
  logic [VW-1:0] buf_r [ARRAY_SIZE];
  logic [VW-1:0] weights_r;
  logic          load_r, busy_r, done_r, w_ready_r, a_ready_r;

  // Next-state, counters and handshake accepts
  always_comb begin
    state_s     = state_r;
    row_cnt_s   = row_cnt_r;
    load_idx_s  = load_idx_r;
    drain_cnt_s = drain_cnt_r;
    w_acc_s     = 1'b0;
    a_acc_s     = 1'b0;
    case (state_r)
      S_FILL: begin
        w_acc_s = w_valid;
        if (w_valid) begin
          if (row_cnt_r == IDX_LAST) begin
            row_cnt_s  = {IW{1'b0}};
            load_idx_s = {IW{1'b0}};
            state_s    = S_LOAD;
          end else begin
            row_cnt_s = row_cnt_r + 1'b1;
          end
        end else begin
          row_cnt_s = row_cnt_r;
        end
      end
      S_LOAD: begin
        if (load_idx_r == IDX_LAST) begin
          load_idx_s = {IW{1'b0}};
          state_s    = S_STREAM;
        end else begin
          load_idx_s = load_idx_r + 1'b1;
        end
      end
      S_STREAM: begin
        a_acc_s = a_valid;
        if (a_valid && a_last) begin
          drain_cnt_s = {CW{1'b0}};
          state_s     = S_DRAIN;
        end else begin
          state_s = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_r == CNT_LAST) begin
          drain_cnt_s = {CW{1'b0}};
          state_s     = S_FILL;
        end else begin
          drain_cnt_s = drain_cnt_r + 1'b1;
        end
      end
      default: begin
        state_s = S_FILL;
      end
    endcase
    done_s    = (state_s == S_DRAIN) && (drain_cnt_s == CNT_LAST);
    skew_in_s = a_acc_s ? a_data : {VW{1'b0}};
  end

  // State, counters and registered outputs (outputs track the next state)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_FILL;
      row_cnt_r   <= {IW{1'b0}};
      load_idx_r  <= {IW{1'b0}};
      drain_cnt_r <= {CW{1'b0}};
      weights_r   <= {VW{1'b0}};
      load_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      w_ready_r   <= 1'b1;
      a_ready_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      row_cnt_r   <= row_cnt_s;
      load_idx_r  <= load_idx_s;
      drain_cnt_r <= drain_cnt_s;
      weights_r   <= (state_s == S_LOAD) ? buf_r[load_idx_s] : {VW{1'b0}};
      load_r      <= (state_s == S_LOAD);
      busy_r      <= (state_s != S_FILL);
      done_r      <= done_s;
      w_ready_r   <= (state_s == S_FILL);
      a_ready_r   <= (state_s == S_STREAM);
    end
  end

  // Weight tile buffer, written in arrival order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < ARRAY_SIZE; k++) begin
        buf_r[k] <= {VW{1'b0}};
      end
    end else if (w_acc_s) begin
      buf_r[row_cnt_r] <= w_data;
    end
  end

  // Lane i is delayed i+1 cycles so the array sees a diagonal wavefront
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] pipe_r [i+1];

    // Per-lane skew shift register
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int j = 0; j <= i; j++) begin
          pipe_r[j] <= {DATA_WIDTH{1'b0}};
        end
      end else begin
        pipe_r[0] <= skew_in_s[i*DATA_WIDTH +: DATA_WIDTH];
        for (int j = 1; j <= i; j++) begin
          pipe_r[j] <= pipe_r[j-1];
        end
      end
    end

    assign activations[i*DATA_WIDTH +: DATA_WIDTH] = pipe_r[i];
  end

  assign weights = weights_r;
  assign load    = load_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign w_ready = w_ready_r;
  assign a_ready = a_ready_r;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: table-driven weight tiles plus a
// scoreboard of expected skewed activations, drain/done timing and resets.
module tb_systolic_feeder;

  localparam int AS = 8;
  localparam int DW = 4;
  localparam int DC = 16;
  localparam int VW = AS * DW;

  logic          clk = 1'b1;
  logic          reset;
  logic          w_valid, w_ready, a_valid, a_ready, a_last;
  logic [VW-1:0] w_data, a_data, weights, activations;
  logic          load, busy, done;

  always #5 clk = ~clk;

  systolic_feeder #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .load(load), .weights(weights), .activations(activations),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [VW-1:0] row;
    bit            gap;
    logic [VW-1:0] exp_w;
  } wvec_t;

  wvec_t         tbl [16];
  logic [VW-1:0] w_q [$];
  logic [VW-1:0] act_q [$];
  logic [VW-1:0] sk_hist [$];
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] splat(input int v);
    logic [DW-1:0] e;
    e = DW'(v);
    return {AS{e}};
  endfunction

  // Expected activations m edges after the first stream edge: lane i = input m-i edges earlier
  function automatic logic [VW-1:0] exp_act(input int m);
    logic [VW-1:0] r;
    logic [VW-1:0] s;
    int idx;
    r = '0;
    for (int i = 0; i < AS; i++) begin
      idx = m - i;
      if (idx >= 0 && idx < sk_hist.size()) begin
        s = sk_hist[idx];
        r[i*DW +: DW] = s[i*DW +: DW];
      end
    end
    return r;
  endfunction

  task automatic do_fill(input int base, input bit hold_junk);
    for (int k = 0; k < AS; k++) begin
      if (tbl[base+k].gap) begin
        w_valid = 1'b0;
        w_data  = 32'hBAD0BAD0;
        step;
        check1("fill_gap_w_ready", w_ready, 1'b1);
      end
      check1("fill_w_ready", w_ready, 1'b1);
      w_valid = 1'b1;
      w_data  = tbl[base+k].row;
      w_q.push_back(tbl[base+k].exp_w);
      step;
    end
    w_valid = hold_junk;
    w_data  = 32'hDEADBEEF;
    for (int c = 0; c < AS; c++) begin
      check1("load_high", load, 1'b1);
      check("weights", weights, (w_q.size() > 0) ? w_q.pop_front() : 32'hFFFFFFFF);
      check1("load_busy", busy, 1'b1);
      check1("load_w_ready", w_ready, 1'b0);
      check1("load_a_ready", a_ready, 1'b0);
      step;
    end
    w_valid = 1'b0;
    check1("load_end", load, 1'b0);
    check("weights_idle", weights, 32'h0);
    check1("stream_a_ready", a_ready, 1'b1);
    check1("stream_w_ready", w_ready, 1'b0);
  endtask

  task automatic run_stream(input int n_vec, input int bubble_after, input bit with_last, input int base);
    int waited = 0;
    int t = 0;
    int n_cyc;
    int dones = 0;
    bit v;
    logic [VW-1:0] d;
    sk_hist.delete();
    act_q.delete();
    while (a_ready !== 1'b1 && waited < 20) begin
      step;
      waited++;
    end
    check1("a_ready_wait", a_ready, 1'b1);
    n_cyc = n_vec + ((bubble_after >= 0) ? 1 : 0);
    for (int m = 0; m < n_cyc; m++) begin
      if (bubble_after >= 0 && m == bubble_after + 1) begin
        v = 1'b0;
        a_valid = 1'b0;
        a_data  = splat(15);
        a_last  = 1'b1;
      end else begin
        v = 1'b1;
        a_valid = 1'b1;
        a_data  = splat(base + t);
        a_last  = with_last && (t == n_vec - 1);
        t++;
      end
      d = v ? a_data : '0;
      sk_hist.push_back(d);
      act_q.push_back(exp_act(m));
      step;
      check("activations", activations, act_q.pop_front());
      check1("stream_busy", busy, 1'b1);
      if (m < n_cyc - 1 || !with_last) check1("a_ready_hold", a_ready, 1'b1);
    end
    if (!with_last) return;
    a_valid = 1'b1;
    a_data  = '1;
    a_last  = 1'b1;
    for (int k = 0; k <= DC; k++) begin
      if (k > 0) begin
        act_q.push_back(exp_act(n_cyc - 1 + k));
        step;
        check("drain_activations", activations, act_q.pop_front());
      end
      if (k == AS) begin
        a_valid = 1'b0;
        a_last  = 1'b0;
        a_data  = '0;
      end
      check1("done", done, k == DC - 1);
      if (done === 1'b1) dones++;
      check1("drain_busy", busy, k < DC);
      check1("drain_a_ready", a_ready, 1'b0);
      check1("drain_w_ready", w_ready, k >= DC);
    end
    check("done_count", 32'(dones), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      tbl[k].row   = 32'h7A5C3210;
      tbl[k].gap   = 1'b0;
      tbl[k].exp_w = 32'h7A5C3210;
      tbl[k+8].row   = 32'(32'h11111111 * 32'(k + 1));
      tbl[k+8].gap   = 1'b1;
      tbl[k+8].exp_w = 32'(32'h11111111 * 32'(k + 1));
    end
    reset = 1'b1; w_valid = 1'b0; w_data = '0;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    #12;
    check1("rst_load", load, 1'b0);
    check("rst_weights", weights, 32'h0);
    check("rst_activations", activations, 32'h0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_a_ready", a_ready, 1'b0);
    #3 reset = 1'b0;
    #1;
    check1("post_rst_w_ready", w_ready, 1'b1);
    check1("post_rst_a_ready", a_ready, 1'b0);
    check1("post_rst_busy", busy, 1'b0);

    do_fill(0, 1'b0);
    run_stream(8, -1, 1'b1, 0);

    do_fill(8, 1'b1);
    run_stream(8, 3, 1'b1, 0);

    do_fill(0, 1'b0);
    run_stream(3, -1, 1'b0, 0);
    #2 reset = 1'b1;
    a_valid = 1'b0;
    a_last  = 1'b0;
    #1;
    check1("mid_rst_load", load, 1'b0);
    check("mid_rst_weights", weights, 32'h0);
    check("mid_rst_activations", activations, 32'h0);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_done", done, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step;
      check1("mid_rst_no_done", done, 1'b0);
    end
    #4 reset = 1'b0;
    #1;
    check1("mid_rel_w_ready", w_ready, 1'b1);
    check1("mid_rel_a_ready", a_ready, 1'b0);
    do_fill(0, 1'b0);
    run_stream(1, -1, 1'b1, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
